// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state type and default timeout for the SRAM arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_DONE, ARB_RESP} arb_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester and SRAM-controller signals of the arbiter
//   requester side : req, req_we, req_addr0/1, req_wdata0/1 -> done, err, rdata, arb_busy
//   controller side: sram_trigger, sram_we, sram_addr, sram_wdata -> sram_busy, sram_read_data
//   master = requesters + controller, slave = arbiter
interface sram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);

    logic [1:0]        req, req_we, done, err;
    logic [ADDR_W-1:0] req_addr0, req_addr1, sram_addr;
    logic [DATA_W-1:0] req_wdata0, req_wdata1, sram_wdata, sram_read_data, rdata;
    logic              arb_busy, sram_trigger, sram_we, sram_busy;

    modport master (
        output req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, sram_busy, sram_read_data,
        input  done, err, rdata, arb_busy, sram_trigger, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, sram_busy, sram_read_data,
        output done, err, rdata, arb_busy, sram_trigger, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_arbiter_rr.sv
// rr_arbiter2: combinational 2-way round-robin pick
//   req       in  pending requests
//   last_gnt  in  previous winner
//   gnt_idx   out chosen requester
//   gnt_valid out any request pending
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    assign gnt_valid = |req;
    // on a tie the requester that did not win last time goes next
    assign gnt_idx   = &req ? ~last_gnt : req[1];

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one SRAM controller port between two requesters
//   clk, rst  sole clock, synchronous active-high reset
//   bus       sram_arbiter_if.slave: requester request/done/err/rdata and controller trigger/busy
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W         = 17,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       state;
    logic             pick, pick_valid, gnt_idx, last_gnt, timed_out;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt_mask;

    rr_arbiter2 u_rr (
        .req      (bus.req),
        .last_gnt (last_gnt),
        .gnt_idx  (pick),
        .gnt_valid(pick_valid)
    );

    // every output is a register or a decode of registered state
    assign gnt_mask         = gnt_idx ? 2'b10 : 2'b01;
    assign bus.sram_trigger = state == ARB_ISSUE;
    assign bus.arb_busy     = state != ARB_IDLE;
    assign bus.done         = state == ARB_RESP ? gnt_mask : 2'b00;
    assign bus.err          = state == ARB_RESP && timed_out ? gnt_mask : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_IDLE;
            last_gnt       <= 1'b1;
            gnt_idx        <= 1'b0;
            timed_out      <= 1'b0;
            cnt            <= '0;
            bus.sram_we    <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.rdata      <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (pick_valid) begin
                    state          <= ARB_ISSUE;
                    gnt_idx        <= pick;
                    last_gnt       <= pick;
                    timed_out      <= 1'b0;
                    cnt            <= '0;
                    bus.sram_we    <= bus.req_we[pick];
                    bus.sram_addr  <= pick ? bus.req_addr1 : bus.req_addr0;
                    bus.sram_wdata <= pick ? bus.req_wdata1 : bus.req_wdata0;
                end
                ARB_ISSUE: begin
                    // saturating, so a late busy can never alias a wrapped count
                    cnt <= cnt == CNT_MAX ? cnt : cnt + 1'b1;
                    if (bus.sram_busy) begin
                        state <= ARB_WAIT_DONE;
                    end else if (cnt == CNT_MAX) begin
                        state     <= ARB_RESP;
                        timed_out <= 1'b1;
                    end
                end
                ARB_WAIT_DONE: if (!bus.sram_busy) begin
                    state <= ARB_RESP;
                    if (!bus.sram_we) bus.rdata <= bus.sram_read_data;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_sram_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus ();

    sram_arbiter #(.ADDR_W(17), .DATA_W(8), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend    [2];
    logic        p_we    [2];
    logic [16:0] p_addr  [2];
    logic [7:0]  p_wdata [2];
    int          last;
    logic [7:0]  exp_rdata;
    logic [7:0]  mem [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [16:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : a[7:0] ^ 8'h5a;
    endfunction

    task automatic apply();
        bus.req        = {pend[1], pend[0]};
        bus.req_we     = {p_we[1], p_we[0]};
        bus.req_addr0  = p_addr[0];
        bus.req_addr1  = p_addr[1];
        bus.req_wdata0 = p_wdata[0];
        bus.req_wdata1 = p_wdata[1];
    endtask

    task automatic new_req(input int r, input logic we, input logic [16:0] a, input logic [7:0] d);
        pend[r]    = 1'b1;
        p_we[r]    = we;
        p_addr[r]  = a;
        p_wdata[r] = d;
    endtask

    task automatic check_reset_vals();
        check("rst_arb_busy", bus.arb_busy, 0);
        check("rst_trigger", bus.sram_trigger, 0);
        check("rst_sram_we", bus.sram_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_wdata", bus.sram_wdata, 0);
        check("rst_rdata", bus.rdata, 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply();
        bus.sram_busy = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst       = 1'b0;
        last      = 1;
        exp_rdata = 8'h00;
    endtask

    // d: cycles from first trigger to busy rising (>TO means never), len: busy cycles
    task automatic run_txn(input int d, input int len, input bit drop);
        int         w, jt, jd;
        bit         to;
        logic [7:0] rd;
        logic [1:0] onehot;
        @(negedge clk);
        check("idle_arb_busy", bus.arb_busy, 0);
        check("idle_done", bus.done, 0);
        apply();
        w      = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        last   = w;
        to     = d > TO;
        jt     = to ? 1 + TO : 1 + d;
        jd     = to ? 2 + TO : 2 + d + len;
        rd     = mem_rd(p_addr[w]);
        onehot = w == 1 ? 2'b10 : 2'b01;
        for (int j = 1; j <= jd; j++) begin
            @(negedge clk);
            check("arb_busy", bus.arb_busy, 1);
            check("trigger", bus.sram_trigger, j <= jt);
            check("sram_we", bus.sram_we, p_we[w]);
            check("sram_addr", bus.sram_addr, p_addr[w]);
            if (p_we[w]) check("sram_wdata", bus.sram_wdata, p_wdata[w]);
            check("done", bus.done, j == jd ? onehot : 2'b00);
            if (j == jd) begin
                check("err", bus.err, to ? onehot : 2'b00);
                if (!to && !p_we[w]) exp_rdata = rd;
                if (!to && p_we[w]) mem[int'(p_addr[w])] = p_wdata[w];
                check("rdata", bus.rdata, exp_rdata);
                pend[w] = 1'b0;
            end
            bus.sram_busy      = !to && j >= 1 + d && j < 1 + d + len;
            bus.sram_read_data = rd;
            if (drop && j == 1) begin
                pend[w] = 1'b0;
                apply();
            end
        end
    endtask

    task automatic idle_check(input int n);
        apply();
        repeat (n) begin
            @(negedge clk);
            check("quiet_arb_busy", bus.arb_busy, 0);
            check("quiet_trigger", bus.sram_trigger, 0);
            check("quiet_done", bus.done, 0);
        end
    endtask

    function automatic logic [16:0] rand_addr();
        return {$urandom_range(0, 1) == 1 ? 14'h3fff : 14'h0000, 3'($urandom_range(0, 7))};
    endfunction

    initial begin
        for (int r = 0; r < 2; r++) begin
            pend[r]    = 1'b0;
            p_we[r]    = 1'b0;
            p_addr[r]  = '0;
            p_wdata[r] = '0;
        end
        bus.sram_busy      = 1'b0;
        bus.sram_read_data = 8'h00;
        do_reset();

        mem[32'h10] = 8'ha5;
        new_req(0, 1'b0, 17'h00010, 8'h00);
        run_txn(1, 3, 1'b0);
        check("single_read_rdata", bus.rdata, 8'ha5);

        do_reset();
        new_req(0, 1'b0, 17'h00123, 8'h00);
        new_req(1, 1'b0, 17'h1abcd, 8'h00);
        for (int t = 0; t < 4; t++) begin
            run_txn(1, 1, 1'b0);
            new_req(last, 1'b0, last == 1 ? 17'h1abcd : 17'h00123, 8'h00);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle_check(2);

        new_req(1, 1'b1, 17'h1ffff, 8'h3c);
        run_txn(2, 2, 1'b0);
        new_req(1, 1'b0, 17'h1ffff, 8'h00);
        run_txn(1, 2, 1'b0);
        check("readback_rdata", bus.rdata, 8'h3c);

        new_req(0, 1'b0, 17'h00055, 8'h00);
        run_txn(99, 0, 1'b0);
        idle_check(2);
        new_req(0, 1'b0, 17'h00056, 8'h00);
        run_txn(1, 1, 1'b0);

        new_req(0, 1'b0, 17'h00777, 8'h00);
        @(negedge clk);
        apply();
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            bus.sram_busy = j >= 2;
        end
        check("wait_arb_busy", bus.arb_busy, 1);
        check("wait_trigger", bus.sram_trigger, 0);
        do_reset();
        new_req(1, 1'b0, 17'h00aaa, 8'h00);
        new_req(0, 1'b0, 17'h00bbb, 8'h00);
        run_txn(1, 1, 1'b0);
        pend[1] = 1'b0;

        new_req(0, 1'b0, 17'h00abc, 8'h00);
        run_txn(2, 2, 1'b1);
        idle_check(3);

        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 2) != 0)
                    new_req(r, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            if (!pend[0] && !pend[1]) new_req(0, 1'b0, rand_addr(), 8'h00);
            run_txn($urandom_range(0, 7) == 0 ? 99 : $urandom_range(1, 3),
                    $urandom_range(1, 3), $urandom_range(0, 5) == 0);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle_check(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
